// File: rtl/cpu_pkg.sv
// Shared CPU types and sizes used by the store buffer and its load-match logic.
package cpu_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  localparam int unsigned PHY_TAG_W        = 6;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned WADDR_W          = ADDR_W - 2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Word-address match over buffered stores plus the incoming push, with a
// rotate-from-write-pointer priority encoder selecting the youngest match.
module sb_fwd_match
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]   valid_i,
  input  logic [WADDR_W-1:0] waddr_i [DEPTH],
  input  logic [PTR_W-1:0]   wr_idx_i,
  input  logic               push_i,
  input  logic [WADDR_W-1:0] push_waddr_i,
  input  logic [WADDR_W-1:0] ld_waddr_i,
  output logic               hit_c_o,
  output logic               push_hit_c_o,
  output logic [PTR_W-1:0]   idx_c_o
);

  logic [DEPTH-1:0] match_c;
  logic             found_c;

  always_comb begin
    match_c      = '0;
    found_c      = 1'b0;
    idx_c_o      = '0;
    push_hit_c_o = push_i && (push_waddr_i == ld_waddr_i);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_c[i] = valid_i[i] && (waddr_i[i] == ld_waddr_i);
    end
    // Walk backwards from the slot just below wr_idx: first hit is the youngest.
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      logic [PTR_W-1:0] j;
      j = PTR_W'(32'(wr_idx_i) + DEPTH - k);
      if (!found_c && match_c[j]) begin
        found_c = 1'b1;
        idx_c_o = j;
      end
    end
    hit_c_o = found_c | push_hit_c_o;
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order drain to the data cache, load address match.
// Define SB_FORWARD_EN to return the youngest matching store's data on SB_LdData.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned SB_PTR_W = $clog2(SB_DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Resetb,
  input  logic                 Rob_CommitMemWrite,
  input  logic [ADDR_W-1:0]    Rob_SwAddr,
  input  logic [PHY_TAG_W-1:0] Rob_CommitCurrPhyAddr,
  output logic [PHY_TAG_W-1:0] SB_RfRdAddr,
  input  logic [DATA_W-1:0]    Rf_SbData,
  output logic                 SB_Full,
  output logic                 SB_DataValid,
  output logic [ADDR_W-1:0]    SB_AddrDmem,
  output logic [DATA_W-1:0]    SB_DataDmem,
  input  logic                 DCE_WriteDone,
  input  logic [ADDR_W-1:0]    Lsq_LdAddr,
  output logic                 SB_LdHit,
  output logic [DATA_W-1:0]    SB_LdData
);

  sb_entry_t           entries_q [SB_DEPTH];
  logic [SB_PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SB_PTR_W-1:0] wr_idx_c, rd_idx_c, fwd_idx_c;
  logic                empty_c, full_c, push_c, pop_c, push_hit_c;
  logic [SB_DEPTH-1:0] valid_c;
  logic [WADDR_W-1:0]  waddr_c [SB_DEPTH];

  assign wr_idx_c = wr_ptr_q[SB_PTR_W-1:0];
  assign rd_idx_c = rd_ptr_q[SB_PTR_W-1:0];
  assign empty_c  = (wr_ptr_q == rd_ptr_q);
  // Decoded from registered pointers only, so ROB commit sees no loop through here.
  assign full_c   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {SB_PTR_W{1'b0}}});
  assign push_c   = Rob_CommitMemWrite & ~full_c;
  assign pop_c    = DCE_WriteDone & ~empty_c;
  assign wr_ptr_d = wr_ptr_q + (SB_PTR_W + 1)'(push_c);
  assign rd_ptr_d = rd_ptr_q + (SB_PTR_W + 1)'(pop_c);

  always_ff @(posedge Clk or posedge Resetb) begin
    if (Resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Push and pop never share a slot: push needs not-full, pop needs not-empty.
      if (push_c) begin
        entries_q[wr_idx_c] <= '{valid: 1'b1, addr: Rob_SwAddr, data: Rf_SbData};
      end
      if (pop_c) begin
        entries_q[rd_idx_c].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    valid_c = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      valid_c[i] = entries_q[i].valid;
      waddr_c[i] = entries_q[i].addr[ADDR_W-1:2];
    end
  end

  assign SB_RfRdAddr  = Rob_CommitCurrPhyAddr;
  assign SB_Full      = full_c;
  assign SB_DataValid = ~empty_c;
  assign SB_AddrDmem  = empty_c ? '0 : entries_q[rd_idx_c].addr;
  assign SB_DataDmem  = empty_c ? '0 : entries_q[rd_idx_c].data;

  sb_fwd_match #(
    .DEPTH (SB_DEPTH),
    .PTR_W (SB_PTR_W)
  ) u_match (
    .valid_i      (valid_c),
    .waddr_i      (waddr_c),
    .wr_idx_i     (wr_idx_c),
    .push_i       (Rob_CommitMemWrite),
    .push_waddr_i (Rob_SwAddr[ADDR_W-1:2]),
    .ld_waddr_i   (Lsq_LdAddr[ADDR_W-1:2]),
    .hit_c_o      (SB_LdHit),
    .push_hit_c_o (push_hit_c),
    .idx_c_o      (fwd_idx_c)
  );

`ifdef SB_FORWARD_EN
  assign SB_LdData = push_hit_c ? Rf_SbData :
                     SB_LdHit   ? entries_q[fwd_idx_c].data : '0;
`else
  assign SB_LdData = '0;
`endif

  logic unused_c;
  assign unused_c = ^{Lsq_LdAddr[1:0], push_hit_c, fwd_idx_c};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed tables, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = cpu_pkg::SB_DEPTH_DEFAULT;

  logic        Clk = 1'b0;
  logic        Resetb;
  logic        Rob_CommitMemWrite;
  logic [31:0] Rob_SwAddr;
  logic [5:0]  Rob_CommitCurrPhyAddr;
  logic [5:0]  SB_RfRdAddr;
  logic [31:0] Rf_SbData;
  logic        SB_Full, SB_DataValid, DCE_WriteDone, SB_LdHit;
  logic [31:0] SB_AddrDmem, SB_DataDmem, Lsq_LdAddr, SB_LdData;

  store_buffer dut (
    .Clk(Clk), .Resetb(Resetb),
    .Rob_CommitMemWrite(Rob_CommitMemWrite), .Rob_SwAddr(Rob_SwAddr),
    .Rob_CommitCurrPhyAddr(Rob_CommitCurrPhyAddr), .SB_RfRdAddr(SB_RfRdAddr),
    .Rf_SbData(Rf_SbData), .SB_Full(SB_Full), .SB_DataValid(SB_DataValid),
    .SB_AddrDmem(SB_AddrDmem), .SB_DataDmem(SB_DataDmem),
    .DCE_WriteDone(DCE_WriteDone), .Lsq_LdAddr(Lsq_LdAddr),
    .SB_LdHit(SB_LdHit), .SB_LdData(SB_LdData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          commit;
    logic [31:0] addr;
    logic [31:0] data;
    bit          done;
    logic [31:0] ld;
    bit          exp_full;
    bit          exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    bit          exp_hit;
    logic [31:0] exp_fwd;
  } vec_t;

  ent_t mq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_cnt  = 0;
  int   rd_cnt  = 0;
  bit   cur_commit, cur_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_val(input logic [31:0] v);
`ifdef SB_FORWARD_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Drive one cycle's inputs (called after a negedge) and check against the model.
  task automatic drive(input bit commit_req, input logic [31:0] a, input logic [31:0] d,
                       input bit done, input logic [31:0] ld);
    bit          e_hit;
    logic [31:0] e_data;
    logic [5:0]  tag;
    tag        = 6'($urandom_range(0, 63));
    cur_commit = commit_req && (mq.size() < DEPTH);
    cur_done   = done;
    Rob_CommitMemWrite    = cur_commit;
    Rob_SwAddr            = a;
    Rf_SbData             = d;
    Rob_CommitCurrPhyAddr = tag;
    DCE_WriteDone         = done;
    Lsq_LdAddr            = ld;
    #1;
    e_hit  = 1'b0;
    e_data = 32'h0;
    if (cur_commit && a[31:2] == ld[31:2]) begin
      e_hit  = 1'b1;
      e_data = d;
    end else begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_hit && mq[i].addr[31:2] == ld[31:2]) begin
          e_hit  = 1'b1;
          e_data = mq[i].data;
        end
      end
    end
    chk("full",   32'(SB_Full),      32'(mq.size() == DEPTH));
    chk("valid",  32'(SB_DataValid), 32'(mq.size() != 0));
    chk("addr",   SB_AddrDmem, (mq.size() != 0) ? mq[0].addr : 32'h0);
    chk("data",   SB_DataDmem, (mq.size() != 0) ? mq[0].data : 32'h0);
    chk("ldhit",  32'(SB_LdHit), 32'(e_hit));
    chk("lddata", SB_LdData, fwd_val(e_data));
    chk("rfaddr", 32'(SB_RfRdAddr), 32'(tag));
    if (Rob_CommitMemWrite && SB_Full) begin
      n_fail++;
      $display("FAIL push_full: commit=1 while SB_Full=1 at %0t", $time);
    end
  endtask

  // Advance through the posedge, update the model, land on the next negedge.
  task automatic tick();
    logic [31:0] a, d;
    a = Rob_SwAddr;
    d = Rf_SbData;
    @(posedge Clk);
    if (cur_done && mq.size() != 0) begin
      void'(mq.pop_front());
      rd_cnt++;
    end
    if (cur_commit) begin
      mq.push_back('{addr: a, data: d});
      wr_cnt++;
    end
    @(negedge Clk);
    Rob_CommitMemWrite = 1'b0;
    DCE_WriteDone      = 1'b0;
  endtask

  task automatic do_reset();
    Resetb = 1'b1;
    mq.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    @(negedge Clk);
    Resetb = 1'b0;
  endtask

  task automatic chk_ptrs(input string name);
    chk({name, "_wr"}, 32'(dut.wr_ptr_q), 32'(wr_cnt % (2 * DEPTH)));
    chk({name, "_rd"}, 32'(dut.rd_ptr_q), 32'(rd_cnt % (2 * DEPTH)));
  endtask

  vec_t vt[9];

  initial begin
    Resetb = 1'b1;
    Rob_CommitMemWrite = 1'b0; Rob_SwAddr = '0; Rob_CommitCurrPhyAddr = '0;
    Rf_SbData = '0; DCE_WriteDone = 1'b0; Lsq_LdAddr = '0;
    cur_commit = 1'b0; cur_done = 1'b0;
    @(negedge Clk);
    chk("rst_full",  32'(SB_Full), 0);
    chk("rst_valid", 32'(SB_DataValid), 0);
    chk("rst_hit",   32'(SB_LdHit), 0);
    Resetb = 1'b0;

    // Idle with stray done pulses.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'(i % 2), 32'h0000_1000);
      tick();
    end

    vt[0] = '{1, 32'h1000, 32'hDEAD_BEEF, 0, 32'h0,    0, 0, 32'h0,    32'h0,         0, 32'h0};
    vt[1] = '{1, 32'h1004, 32'h1234_5678, 0, 32'h0,    0, 1, 32'h1000, 32'hDEAD_BEEF, 0, 32'h0};
    vt[2] = '{0, 32'h0,    32'h0,         0, 32'h1004, 0, 1, 32'h1000, 32'hDEAD_BEEF, 1, 32'h1234_5678};
    vt[3] = '{0, 32'h0,    32'h0,         1, 32'h0,    0, 1, 32'h1000, 32'hDEAD_BEEF, 0, 32'h0};
    vt[4] = '{0, 32'h0,    32'h0,         0, 32'h1000, 0, 1, 32'h1004, 32'h1234_5678, 0, 32'h0};
    vt[5] = '{0, 32'h0,    32'h0,         1, 32'h0,    0, 1, 32'h1004, 32'h1234_5678, 0, 32'h0};
    vt[6] = '{0, 32'h0,    32'h0,         0, 32'h1004, 0, 0, 32'h0,    32'h0,         0, 32'h0};
    vt[7] = '{0, 32'h0,    32'h0,         1, 32'h0,    0, 0, 32'h0,    32'h0,         0, 32'h0};
    vt[8] = '{1, 32'h1008, 32'h0000_0077, 0, 32'h100A, 0, 0, 32'h0,    32'h0,         1, 32'h77};
    foreach (vt[i]) begin
      drive(vt[i].commit, vt[i].addr, vt[i].data, vt[i].done, vt[i].ld);
      chk($sformatf("v%0d_full", i),  32'(SB_Full),      32'(vt[i].exp_full));
      chk($sformatf("v%0d_valid", i), 32'(SB_DataValid), 32'(vt[i].exp_valid));
      chk($sformatf("v%0d_addr", i),  SB_AddrDmem, vt[i].exp_addr);
      chk($sformatf("v%0d_data", i),  SB_DataDmem, vt[i].exp_data);
      chk($sformatf("v%0d_hit", i),   32'(SB_LdHit), 32'(vt[i].exp_hit));
      chk($sformatf("v%0d_fwd", i),   SB_LdData, fwd_val(vt[i].exp_fwd));
      tick();
    end

    // Fill, then done alongside a gated commit, then wrap with paired push/pop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h5000 + 32'(4 * i), 32'hC000 + 32'(i), 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 32'h5010, 32'hC004, 1'b1, 32'h0);
    chk("full_after4", 32'(SB_Full), 1);
    chk("full_gated",  32'(Rob_CommitMemWrite), 0);
    tick();
    drive(1'b1, 32'h5010, 32'hC004, 1'b0, 32'h0);
    chk("full_released", 32'(SB_Full), 0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h6000 + 32'(4 * i), 32'hD000 + 32'(i), 1'b1, 32'h6000);
      tick();
    end
    chk("pair_occ", 32'(mq.size()), 3);
    chk_ptrs("wrap");

    // Two stores to the same word: youngest wins.
    do_reset();
    drive(1'b1, 32'h2000, 32'hA, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h2000, 32'hB, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h2002);
    chk("same_hit", 32'(SB_LdHit), 1);
    chk("same_fwd", SB_LdData, fwd_val(32'hB));
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h2004);
    chk("other_hit", 32'(SB_LdHit), 0);
    tick();

    // Randomized traffic over a small address pool.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            32'h3000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
            $urandom(), 1'($urandom_range(0, 2) == 0),
            32'h3000 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3)));
      tick();
    end
    chk_ptrs("rand");

    // Async reset with entries pending.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h7000 + 32'(4 * i), 32'hE000 + 32'(i), 1'b0, 32'h0);
      tick();
    end
    Lsq_LdAddr = 32'h7004;
    #1;
    chk("pre_rst_valid", 32'(SB_DataValid), 1);
    #2;
    Resetb = 1'b1;
    #1;
    chk("arst_valid", 32'(SB_DataValid), 0);
    chk("arst_full",  32'(SB_Full), 0);
    chk("arst_addr",  SB_AddrDmem, 32'h0);
    chk("arst_data",  SB_DataDmem, 32'h0);
    chk("arst_hit",   32'(SB_LdHit), 0);
    chk("arst_fwd",   SB_LdData, 32'h0);
    mq.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    @(negedge Clk);
    Resetb = 1'b0;
    drive(1'b1, 32'h4000, 32'h4444, 1'b0, 32'h0);
    tick();
    chk("post_rst_wr",   32'(dut.wr_ptr_q), 1);
    chk("post_rst_slot", dut.entries_q[0].addr, 32'h4000);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Post-commit store buffer sitting directly downstream of the reorder buffer.
- On each committed store (Rob_CommitMemWrite), it captures the store word address from Rob_SwAddr. It captures the store data by reading the physical register named by Rob_CommitCurrPhyAddr.
- Entries are drained in order to the data-cache write port using a valid/done handshake.
- SB_Full feeds back to gate ROB commit. An address-match port lets the LSQ detect, and optionally forward from, pending stores.

Parameters:
- SB_DEPTH, 4: number of entries; power of two, 2..16.
- SB_PTR_W, $clog2(SB_DEPTH): entry index width. Pointers are SB_PTR_W+1 bits wide, with the wrap bit as MSB.

Ports:
- Clk  in  1  system clock; all state on posedge.
- Resetb  in  1  asynchronous reset, active-high.
- Rob_CommitMemWrite  in  1  ROB commits a store this cycle; push one entry.
- Rob_SwAddr  in  32  byte address of committing store.
- Rob_CommitCurrPhyAddr  in  6  physical register holding the store data (rt tag).
- SB_RfRdAddr  out  6  register-file read address; combinational copy of Rob_CommitCurrPhyAddr.
- Rf_SbData  in  32  register-file read data; combinational, same cycle.
- SB_Full  out  1  buffer cannot accept a push this cycle.
- SB_DataValid  out  1  head entry presented to data cache.
- SB_AddrDmem  out  32  head entry address.
- SB_DataDmem  out  32  head entry data.
- DCE_WriteDone  in  1  data cache accepted head entry this cycle; pop.
- Lsq_LdAddr  in  32  address of load probing the buffer.
- SB_LdHit  out  1  a pending store matches the load word address.
- SB_LdData  out  32  data of the youngest matching store (SB_FORWARD_EN only; otherwise 0).

Behaviour:
- Reset (Resetb=1, async):
  - all valid bits cleared; wr_ptr = rd_ptr = 0.
  - SB_Full=0, SB_DataValid=0, SB_LdHit=0.
  - SB_AddrDmem, SB_DataDmem and SB_LdData are driven 0 while empty.
  - Reset mid-drain discards all entries, including any not yet acknowledged.
- Entry contents: valid (1), addr (32), data (32).
- Push: when Rob_CommitMemWrite=1, write {1, Rob_SwAddr, Rf_SbData} at wr_ptr[SB_PTR_W-1:0] and increment wr_ptr. There is no write latency beyond the clock edge.
- Pop: when SB_DataValid=1 and DCE_WriteDone=1, clear the head valid bit and increment rd_ptr.
  - DCE_WriteDone while empty is ignored.
- SB_Full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}, decoded from registered pointers only.
  - It has no combinational path from Rob_CommitMemWrite or DCE_WriteDone, to avoid a loop through ROB commit.
  - When full and a pop occurs the same cycle, SB_Full stays 1 for that cycle; the push is accepted the next cycle.
- Simultaneous push and pop (not full, not empty): both occur and the occupancy is unchanged.
- Push while full: protocol violation. The ROB guarantees it cannot happen; the bench asserts it never occurs.
- Drain output is combinational from the head entry: SB_DataValid = ~empty. Head address and data are held stable until DCE_WriteDone.
- Wrap-around: pointers count modulo 2*SB_DEPTH; the MSB distinguishes full from empty.
- No flush input: committed stores are architecturally retired and are never cancelled by a branch mispredict.
- Load match:
  - Compare Lsq_LdAddr[31:2] against addr[31:2] of all valid entries, plus the same-cycle pushed entry (Rob_CommitMemWrite with Rob_SwAddr).
  - SB_LdHit = OR of all matches. The result is combinational.
  - Youngest means closest to wr_ptr, and the incoming push counts as youngest.

Optional Feature:
- SB_FORWARD_EN defined:
  - SB_LdData returns the data of the youngest matching entry; the incoming push uses Rf_SbData.
  - The LSQ completes the load from SB_LdData when SB_LdHit=1.
- SB_FORWARD_EN undefined:
  - no priority mux is built and SB_LdData is tied to 0.
  - SB_LdHit is a stall-only indication: the LSQ must hold the load until the hit deasserts.

Decomposition:
- Shared package (cpu_pkg):
  - SB_DEPTH default.
  - PHY_TAG_W=6, DATA_W=32.
  - sb_entry_t struct {valid, addr, data}.
- One natural sub-module: sb_fwd_match. It takes entries, pointers and the incoming push, and returns hit plus youngest index via a rotate-from-wr_ptr priority encoder. It is shared with future load-queue logic.

Test Plan:
- Reset then idle: SB_Full=0, SB_DataValid=0 and SB_LdHit=0 every cycle; DCE_WriteDone pulses ignored.
- Push 0x0000_1000/0xDEAD_BEEF, then 0x0000_1004/0x1234_5678, with no done: SB_DataValid=1 and SB_AddrDmem=0x1000 is held. Done pulse: the head becomes 0x1004/0x1234_5678.
- Four pushes with DEPTH=4 and no drain: SB_Full=1 after the 4th edge. A done pulse the same cycle as a commit attempt leaves SB_Full=1 that cycle and 0 the next. The bench asserts no push while full.
- Ten push/pop pairs in the same cycles: occupancy is constant, the pointers wrap past 7→0, and the data order is preserved (FIFO check against the model).
- Entries 0x2000/0xA and 0x2000/0xB pending, Lsq_LdAddr=0x2002: SB_LdHit=1, and SB_LdData=0xB with SB_FORWARD_EN (0 without). Lsq_LdAddr=0x2004: SB_LdHit=0.
- Reset asserted with 3 entries pending and SB_DataValid=1: all outputs are 0 immediately (async), and the first push after release appears at index 0.
